// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with out-of-order completion
// Optional feature: define ROB_FLUSH_EN to add i_flush (clears every entry, highest priority).
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   i_alloc_*            dispatch request and entry payload; o_alloc_ready / o_alloc_tag answer it
//   i_cmpl_valid/tag     marks an entry done
//   o_commit_*           registered retirement of the head entry
//   o_push_free_reg      registered; o_freed_reg carries the stale physical tag
//   o_full, o_empty      occupancy flags from the current count
module reorder_buffer #(
    parameter int DEPTH      = 16,
    parameter int TAG_WIDTH  = 4,
    parameter int PREG_WIDTH = 6,
    parameter int AREG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ROB_FLUSH_EN
    input  logic                  i_flush,
`endif
    input  logic                  i_alloc_valid,
    input  logic                  i_alloc_reg_write,
    input  logic [AREG_WIDTH-1:0] i_alloc_rd,
    input  logic [PREG_WIDTH-1:0] i_alloc_rrd,
    input  logic [PREG_WIDTH-1:0] i_alloc_old_rd,
    input  logic [11:0]           i_alloc_pc,
    output logic                  o_alloc_ready,
    output logic [TAG_WIDTH-1:0]  o_alloc_tag,
    input  logic                  i_cmpl_valid,
    input  logic [TAG_WIDTH-1:0]  i_cmpl_tag,
    output logic                  o_commit_valid,
    output logic [11:0]           o_commit_pc,
    output logic [AREG_WIDTH-1:0] o_commit_rd,
    output logic [PREG_WIDTH-1:0] o_commit_rrd,
    output logic                  o_push_free_reg,
    output logic [PREG_WIDTH-1:0] o_freed_reg,
    output logic                  o_full,
    output logic                  o_empty
);
    logic [DEPTH-1:0]      r_valid, r_done, r_reg_write;
    logic [AREG_WIDTH-1:0] r_rd [DEPTH];
    logic [PREG_WIDTH-1:0] r_rrd [DEPTH];
    logic [PREG_WIDTH-1:0] r_old_rd [DEPTH];
    logic [11:0]           r_pc [DEPTH];
    logic [TAG_WIDTH-1:0]  r_head, r_tail;
    logic [TAG_WIDTH:0]    r_count;
    logic                  w_flush, w_alloc_fire, w_commit_fire;
`ifdef ROB_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif
    assign o_full        = r_count == (TAG_WIDTH+1)'(DEPTH);
    assign o_empty       = r_count == '0;
    assign o_alloc_ready = ~o_full;
    assign o_alloc_tag   = r_tail;
    assign w_alloc_fire  = i_alloc_valid & ~o_full & ~w_flush;
    // done is read from registered state only, so a completion retires one edge later at the earliest
    assign w_commit_fire = r_valid[r_head] & r_done[r_head] & ~w_flush;
    // Payload needs no reset: it is only observed once its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_reg_write[r_tail] <= i_alloc_reg_write;
            r_rd[r_tail]        <= i_alloc_rd;
            r_rrd[r_tail]       <= i_alloc_rrd;
            r_old_rd[r_tail]    <= i_alloc_old_rd;
            r_pc[r_tail]        <= i_alloc_pc;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid         <= '0;
            r_done          <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            o_commit_valid  <= 1'b0;
            o_commit_pc     <= '0;
            o_commit_rd     <= '0;
            o_commit_rrd    <= '0;
            o_push_free_reg <= 1'b0;
            o_freed_reg     <= '0;
        end else if (w_flush) begin
            r_valid         <= '0;
            r_done          <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            o_commit_valid  <= 1'b0;
            o_push_free_reg <= 1'b0;
        end else begin
            // An allocating slot is never valid, so completion and allocation cannot collide.
            if (i_cmpl_valid && r_valid[i_cmpl_tag])
                r_done[i_cmpl_tag] <= 1'b1;
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + TAG_WIDTH'(1);
            end
            if (w_commit_fire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + TAG_WIDTH'(1);
                o_commit_pc     <= r_pc[r_head];
                o_commit_rd     <= r_rd[r_head];
                o_commit_rrd    <= r_rrd[r_head];
                o_freed_reg     <= r_old_rd[r_head];
            end
            r_count         <= r_count + (TAG_WIDTH+1)'(w_alloc_fire) - (TAG_WIDTH+1)'(w_commit_fire);
            o_commit_valid  <= w_commit_fire;
            o_push_free_reg <= w_commit_fire & r_reg_write[r_head] & (r_rd[r_head] != '0);
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench with a program-order queue model of the reorder buffer
module tb_reorder_buffer;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic       i_alloc_valid = 0, i_alloc_reg_write = 0, i_cmpl_valid = 0;
    logic [4:0] i_alloc_rd = 0;
    logic [5:0] i_alloc_rrd = 0, i_alloc_old_rd = 0;
    logic [11:0] i_alloc_pc = 0;
    logic [3:0] i_cmpl_tag = 0;
`ifdef ROB_FLUSH_EN
    logic i_flush = 0;
`endif
    logic       o_alloc_ready, o_commit_valid, o_push_free_reg, o_full, o_empty;
    logic [3:0] o_alloc_tag;
    logic [11:0] o_commit_pc;
    logic [4:0] o_commit_rd;
    logic [5:0] o_commit_rrd, o_freed_reg;
    reorder_buffer dut (
        .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
        .i_flush(i_flush),
`endif
        .i_alloc_valid(i_alloc_valid), .i_alloc_reg_write(i_alloc_reg_write),
        .i_alloc_rd(i_alloc_rd), .i_alloc_rrd(i_alloc_rrd), .i_alloc_old_rd(i_alloc_old_rd),
        .i_alloc_pc(i_alloc_pc), .o_alloc_ready(o_alloc_ready), .o_alloc_tag(o_alloc_tag),
        .i_cmpl_valid(i_cmpl_valid), .i_cmpl_tag(i_cmpl_tag),
        .o_commit_valid(o_commit_valid), .o_commit_pc(o_commit_pc), .o_commit_rd(o_commit_rd),
        .o_commit_rrd(o_commit_rrd), .o_push_free_reg(o_push_free_reg), .o_freed_reg(o_freed_reg),
        .o_full(o_full), .o_empty(o_empty)
    );
    typedef struct {
        logic [3:0] tag; logic rw; logic [4:0] rd; logic [5:0] rrd, old; logic [11:0] pc; logic done;
    } ent_t;
    typedef struct {
        logic [11:0] pc; logic [4:0] rd; logic [5:0] rrd, old; logic push;
    } exp_t;
    ent_t q[$];
    exp_t eq[$];
    int next_tag = 0, total = 0, bad = 0;
    logic [5:0] last_freed = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask
    // One cycle, entered and left at a negedge; the model advances by the edge in between.
    task automatic step(input logic av, input logic rw, input logic [4:0] rd, input logic [5:0] rrd,
                        input logic [5:0] old, input logic [11:0] pc, input logic cv, input logic [3:0] ct);
        bit com, can;
        i_alloc_valid = av; i_alloc_reg_write = rw; i_alloc_rd = rd; i_alloc_rrd = rrd;
        i_alloc_old_rd = old; i_alloc_pc = pc; i_cmpl_valid = cv; i_cmpl_tag = ct;
        chk("alloc_tag", 32'(o_alloc_tag), 32'(next_tag));
        chk("full", 32'(o_full), 32'(q.size() == 16));
        chk("empty", 32'(o_empty), 32'(q.size() == 0));
        chk("alloc_ready", 32'(o_alloc_ready), 32'(q.size() < 16));
        com = q.size() > 0 && q[0].done;
        can = q.size() < 16;
        if (cv) foreach (q[i]) if (q[i].tag == ct) q[i].done = 1;
        if (com) begin
            eq.push_back('{q[0].pc, q[0].rd, q[0].rrd, q[0].old, q[0].rw && q[0].rd != 0});
            void'(q.pop_front());
        end
        if (av && can) begin
            q.push_back('{4'(next_tag), rw, rd, rrd, old, pc, 1'b0});
            next_tag = (next_tag + 1) % 16;
        end
        @(negedge clk);
    endtask
    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic rnd_alloc(input logic cv, input logic [3:0] ct);
        step(1, ($urandom % 4) != 0, 5'($urandom_range(0, 3)), 6'($urandom), 6'($urandom), 12'($urandom), cv, ct);
    endtask
    task automatic drain();
        logic [3:0] tags[$];
        int n;
        foreach (q[i]) tags.push_back(q[i].tag);
        foreach (tags[i]) step(0, 0, 0, 0, 0, 0, 1, tags[i]);
        n = 0;
        while (q.size() > 0 && n < 40) begin idle(); n++; end
        idle(); idle();
        chk("drain_empty", 32'(o_empty), 32'd1);
    endtask
`ifdef ROB_FLUSH_EN
    task automatic flush_step();
        i_flush = 1; i_alloc_valid = 1; i_cmpl_valid = 1;
        chk("flush_pre_empty", 32'(o_empty), 32'(q.size() == 0));
        q.delete();
        next_tag = 0;
        @(negedge clk);
        i_flush = 0; i_alloc_valid = 0; i_cmpl_valid = 0;
    endtask
`endif
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst) continue;
        if (o_commit_valid) begin
            if (eq.size() == 0) chk("spurious_commit", 32'd1, 32'd0);
            else begin
                e = eq.pop_front();
                chk("commit_pc", 32'(o_commit_pc), 32'(e.pc));
                chk("commit_rd", 32'(o_commit_rd), 32'(e.rd));
                chk("commit_rrd", 32'(o_commit_rrd), 32'(e.rrd));
                chk("push_free_reg", 32'(o_push_free_reg), 32'(e.push));
                if (e.push) chk("freed_reg", 32'(o_freed_reg), 32'(e.old));
            end
        end else chk("push_idle", 32'(o_push_free_reg), 32'd0);
        if (o_push_free_reg) last_freed = o_freed_reg;
    end
    initial begin
        @(negedge clk);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_tag", 32'(o_alloc_tag), 32'd0);
        chk("rst_commit", 32'(o_commit_valid), 32'd0);
        chk("rst_push", 32'(o_push_free_reg), 32'd0);
        rst = 0;
        for (int i = 0; i < 17; i++) rnd_alloc(0, 0);
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_ready", 32'(o_alloc_ready), 32'd0);
        chk("fill_tail", 32'(o_alloc_tag), 32'd0);
        drain();
        for (int i = 0; i < 3; i++) step(1, 1, 5'(i + 1), 6'(i + 10), 6'(33 + i), 12'(i * 4), 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(); idle();
        chk("ooo_freed0", 32'(last_freed), 32'd33);
        chk("ooo_not_empty", 32'(o_empty), 32'd0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        chk("ooo_freed1", 32'(last_freed), 32'd34);
        idle();
        chk("ooo_freed2", 32'(last_freed), 32'd35);
        idle();
        chk("ooo_empty", 32'(o_empty), 32'd1);
        step(1, 1, 0, 6'd7, 6'd40, 12'h100, 0, 0);
        step(1, 0, 5'd5, 6'd8, 6'd41, 12'h104, 0, 0);
        drain();
        for (int i = 0; i < 5; i++) rnd_alloc(0, 0);
        #2 rst = 1;
        #1;
        chk("arst_empty", 32'(o_empty), 32'd1);
        chk("arst_full", 32'(o_full), 32'd0);
        chk("arst_tag", 32'(o_alloc_tag), 32'd0);
        chk("arst_push", 32'(o_push_free_reg), 32'd0);
        q.delete(); eq.delete(); next_tag = 0;
        @(negedge clk);
        rst = 0;
        rnd_alloc(0, 0);
        for (int i = 1; i < 20; i++) rnd_alloc(1, 4'(i - 1));
        step(0, 0, 0, 0, 0, 0, 1, 4'd3);
        drain();
`ifdef ROB_FLUSH_EN
        for (int i = 0; i < 7; i++) rnd_alloc(0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 4'((next_tag + 9 + i) % 16));
        flush_step();
        chk("flush_empty", 32'(o_empty), 32'd1);
        chk("flush_tag", 32'(o_alloc_tag), 32'd0);
        idle();
`endif
        for (int i = 0; i < 400; i++) begin
            logic cv;
            logic [3:0] ct;
            cv = ($urandom % 3) != 0;
            ct = (q.size() > 0 && ($urandom % 4) != 0) ? q[$urandom % q.size()].tag : 4'($urandom);
            if (($urandom % 3) != 0) rnd_alloc(cv, ct);
            else step(0, 0, 0, 0, 0, 0, cv, ct);
        end
        drain();
        chk("scoreboard_empty", 32'(eq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
